// File: rtl/bank_array_timing_pkg.sv
// bank_array_timing_pkg: command codes, bank states and counter sizing helper
package bank_array_timing_pkg;
  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PR  = 3'd4;
  localparam logic [2:0] CMD_PRA = 3'd5;
  localparam logic [2:0] CMD_REF = 3'd6;
  localparam logic [2:0] CMD_RWA = 3'd7;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_ACTIVE,
    ST_PRECHARGING,
    ST_REFRESHING
  } bank_state_e;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/bank_array_timing_bank_fsm.sv
// bank_array_timing_bank_fsm: one bank's state, timing counter and open row; eff_state is the state a command sees this cycle
module bank_array_timing_bank_fsm
  import bank_array_timing_pkg::*;
#(
  parameter int TRCD = 3,
  parameter int TRP  = 3,
  parameter int TRFC = 8,
  parameter int CW   = 4,
  parameter int RW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  input  logic          act,
  input  logic          pre,
  input  logic          refresh,
  input  logic [RW-1:0] row,
  output bank_state_e   eff_state,
  output logic          busy,
  output logic [RW-1:0] open_row
);
  bank_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic done;
  always_comb begin
    done = cnt_q == '0;
    eff_state = !done ? state_q :
                state_q == ST_ACTIVATING ? ST_ACTIVE :
                state_q inside {ST_PRECHARGING, ST_REFRESHING} ? ST_IDLE : state_q;
    state_d = halt ? state_q : act ? ST_ACTIVATING : pre ? ST_PRECHARGING : refresh ? ST_REFRESHING : eff_state;
    cnt_d = halt ? cnt_q : act ? CW'(TRCD - 1) : pre ? CW'(TRP - 1) : refresh ? CW'(TRFC - 1) :
            done ? cnt_q : cnt_q - CW'(1);
    row_d = !halt && act ? row : row_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  assign busy = state_q != ST_IDLE;
  assign open_row = row_q;
endmodule

// File: rtl/bank_array_timing.sv
// bank_array_timing: multi-bank DRAM emulation core (cmd/bank/row/column/wdata in, rd_valid/rd_data/cmd_err/bank_busy out); cmd=7 is RDA/WRA only when BANKTIMING_AUTOPRE_EN is defined
module bank_array_timing
  import bank_array_timing_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BANKS = 4,
  parameter int ROWS  = 16,
  parameter int COLS  = 8,
  parameter int TRCD  = 3,
  parameter int TRP   = 3,
  parameter int TCL   = 2,
  parameter int TRFC  = 8,
  localparam int BW  = BANKS > 1 ? $clog2(BANKS) : 1,
  localparam int RW  = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CLW = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic             cmd_wr,
  input  logic [BW-1:0]    bank,
  input  logic [RW-1:0]    row,
  input  logic [CLW-1:0]   column,
  input  logic [WIDTH-1:0] wdata,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             cmd_err,
  output logic [BANKS-1:0] bank_busy
);
  localparam int CW = $clog2(max3(TRCD, TRP, TRFC) + 1);
  localparam int AW = BW + RW + CLW;
`ifdef BANKTIMING_AUTOPRE_EN
  localparam bit AUTOPRE = 1'b1;
`else
  localparam bit AUTOPRE = 1'b0;
`endif
  bank_state_e eff [BANKS];
  logic [RW-1:0] open_row [BANKS];
  logic [BANKS-1:0] idle, active, timed, sel, act_s, pre_s, ref_s;
  logic ok, acc, is_rd, is_wr;
  logic [AW-1:0] addr;
  logic [WIDTH-1:0] mem [2**AW];
  logic [TCL-1:0] pv_q, pv_d;
  logic [WIDTH-1:0] pd_q [TCL];
  logic [WIDTH-1:0] pd_d [TCL];
  logic rd_valid_q, rd_valid_d, cmd_err_q, cmd_err_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    bank_array_timing_bank_fsm #(
      .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .CW(CW), .RW(RW)
    ) u_fsm (
      .clk(clk),
      .rst(rst),
      .halt(halt),
      .act(act_s[i]),
      .pre(pre_s[i]),
      .refresh(ref_s[i]),
      .row(row),
      .eff_state(eff[i]),
      .busy(bank_busy[i]),
      .open_row(open_row[i])
    );
    assign idle[i] = eff[i] == ST_IDLE;
    assign active[i] = eff[i] == ST_ACTIVE;
    assign timed[i] = eff[i] inside {ST_ACTIVATING, ST_REFRESHING};
  end
  assign addr = {bank, open_row[bank], column};
  always_comb begin
    ok = cmd == CMD_NOP ? 1'b1 :
         cmd == CMD_ACT ? idle[bank] :
         cmd inside {CMD_RD, CMD_WR} ? active[bank] :
         cmd == CMD_PR ? active[bank] || idle[bank] :
         cmd == CMD_PRA ? !(|timed) :
         cmd == CMD_REF ? &idle :
         AUTOPRE && active[bank];
    acc = cmd_valid && !halt && ok;
    is_rd = acc && (cmd == CMD_RD || (cmd == CMD_RWA && !cmd_wr));
    is_wr = acc && (cmd == CMD_WR || (cmd == CMD_RWA && cmd_wr));
    sel = BANKS'(1) << bank;
    act_s = acc && cmd == CMD_ACT ? sel : '0;
    pre_s = !acc ? '0 : cmd == CMD_PRA ? active : cmd inside {CMD_PR, CMD_RWA} ? sel & active : '0;
    ref_s = {BANKS{acc && cmd == CMD_REF}};
    cmd_err_d = halt ? cmd_err_q : cmd_valid && !ok;
    pv_d = pv_q;
    pd_d = pd_q;
    if (!halt) begin
      pv_d[0] = is_rd;
      pd_d[0] = mem[addr];
      for (int i = 1; i < TCL; i++) begin
        pv_d[i] = pv_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
    end
    rd_valid_d = halt ? rd_valid_q : pv_q[TCL-1];
    rd_data_d = halt ? rd_data_q : pv_q[TCL-1] ? pd_q[TCL-1] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv_q <= '0;
      pd_q <= '{default: '0};
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      pv_q <= pv_d;
      pd_q <= pd_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      cmd_err_q <= cmd_err_d;
    end
  always_ff @(posedge clk)
    if (is_wr) mem[addr] <= wdata;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign cmd_err = cmd_err_q;
endmodule

// File: doc/bank_array_timing.md
Name: bank_array_timing

Overview:
- Multi-bank DRAM emulation core.
- Replaces the single-bank SRAM-plus-timing pairing with BANKS independent bank FSMs. Each FSM has its own timing counters (tRCD, tRP, tRFC) and an open-row register.
- Storage is shared and addressed {bank, open_row, column}. Read data returns after a fixed CAS latency.
- Illegal or too-early commands are flagged and have no effect. Sits between the DDR command decoder and the host-side data path.

Parameters:
- WIDTH, 8, data bits per column access.
- BANKS, 4, number of banks (power of two, ≥1).
- ROWS, 16, rows per bank (power of two).
- COLS, 8, columns per row (power of two).
- TRCD, 3, ACT-to-RD/WR delay in cycles (≥1).
- TRP, 3, PR-to-IDLE delay in cycles (≥1).
- TCL, 2, RD-to-data latency in cycles (≥1).
- TRFC, 8, REF duration in cycles (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- halt  in  1  freezes all state (synchronous clock-enable, no clock gating).
- cmd_valid  in  1  command present this cycle.
- cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PR, 5 PRA, 6 REF, 7 RDA/WRA selector (see optional feature).
- cmd_wr  in  1  with cmd=7: 1 = WRA, 0 = RDA.
- bank  in  $clog2(BANKS)  target bank.
- row  in  $clog2(ROWS)  row, used by ACT.
- column  in  $clog2(COLS)  column, used by RD/WR.
- wdata  in  WIDTH  write data, sampled with WR.
- rd_valid  out  1  read data valid.
- rd_data  out  WIDTH  read data.
- cmd_err  out  1  one-cycle pulse: the command was rejected.
- bank_busy  out  BANKS  per-bank bit: bank not IDLE.

Behaviour:
- Reset: all banks IDLE, counters 0, open rows 0; rd_valid=0, rd_data=0, cmd_err=0, bank_busy=0, read pipeline cleared. Storage contents are not reset.
- halt=1: no state, counter, pipeline or output register changes; cmd is ignored without raising an error.
- Per-bank FSM states: IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING.
- ACT:
  - Legal only in IDLE.
  - Latches row, loads counter TRCD-1, enters ACTIVATING.
  - When the counter reaches 0 the bank moves to ACTIVE on the next edge. RD/WR is therefore legal exactly TRCD cycles after ACT.
- RD:
  - Legal only in ACTIVE.
  - Reads storage[{bank, open_row, column}] into a TCL-deep pipeline.
  - rd_valid=1 and rd_data are valid exactly TCL cycles after the accepted RD edge.
- WR:
  - Legal only in ACTIVE.
  - Writes wdata at the accepted edge. A RD to the same address one cycle later returns the new data.
- PR:
  - Legal in ACTIVE or IDLE. PR in IDLE is a no-op with no error.
  - From ACTIVE: load TRP-1, enter PRECHARGING, then IDLE.
- PRA:
  - Legal only if no bank is ACTIVATING or REFRESHING.
  - Every ACTIVE bank enters PRECHARGING. IDLE banks are unchanged.
- REF:
  - Legal only if every bank is IDLE.
  - All banks enter REFRESHING for TRFC cycles, then IDLE.
- Any command in the wrong state (including during PRECHARGING/ACTIVATING/REFRESHING):
  - cmd_err=1 on the next cycle.
  - No state, storage or pipeline change.
- NOP never errors.
- Reads in flight complete even if the bank is subsequently precharged; the pipeline is independent of bank state.
- Reset mid-operation: everything returns to the reset state immediately, and in-flight reads are discarded.
- Counter width: $clog2(max(TRCD,TRP,TRFC)+1).
- Storage depth: BANKS*ROWS*COLS.

Optional Feature:
- BANKTIMING_AUTOPRE_EN defined: cmd=7 is RDA (cmd_wr=0) or WRA (cmd_wr=1).
  - Same legality and data behaviour as RD/WR.
  - The same edge also loads TRP-1 and moves the bank to PRECHARGING.
- Undefined: cmd=7 is illegal and always produces cmd_err.

Decomposition:
- Shared package: command encoding constants, the bank state enum, and a max() helper for counter sizing.
- One natural sub-module: bank_fsm, one instance per bank. It holds the state, counter and open row, and takes decoded act/rw/pre/ref strobes plus halt.
- Storage, read pipeline and error logic stay in the top.

Test Plan:
- Defaults: ACT b0 r5, then 2 NOPs, WR b0 c3 0xA5, RD b0 c3 -> rd_valid high 2 cycles after RD with rd_data=0xA5; cmd_err stays 0.
- ACT b1, then RD b1 one cycle later (before TRCD) -> cmd_err pulse; no rd_valid; after 3 cycles the RD succeeds.
- ACT b0 and ACT b2, wait, then REF -> cmd_err. PRA, wait 3, REF -> bank_busy=4'b1111 for 8 cycles, then 0.
- halt asserted for 5 cycles during ACTIVATING -> bank stays busy 5 extra cycles; a command issued during halt produces no cmd_err.
- rst asserted asynchronously mid-REF with a RD in flight -> all outputs 0 immediately; no rd_valid afterwards.
- With BANKTIMING_AUTOPRE_EN: WRA b3 c1 0x3C, then ACT b3 3 cycles later -> accepted; a later RD returns 0x3C. Without the macro: cmd=7 -> cmd_err.
